// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared hold/jump encodings, FSM states and helpers
// for the pipeline control unit (trap state present with PIPE_CTRL_TRAP_EN).
package pipe_ctrl_pkg;

   localparam logic [2:0] HOLD_NONE = 3'd0;
   localparam logic [2:0] HOLD_PC   = 3'd1;
   localparam logic [2:0] HOLD_IF   = 3'd2;
   localparam logic [2:0] HOLD_ID   = 3'd3;

   localparam logic JumpEnable  = 1'b1;
   localparam logic JumpDisable = 1'b0;

   localparam int FLUSH_W = 3;
   localparam int WDOG_W  = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FLUSH,
`ifdef PIPE_CTRL_TRAP_EN
      ST_STALL,
      ST_TRAP_WAIT
`else
      ST_STALL
`endif
   } state_e;

   // ex busy freezes the whole front end; a bus stall only the pc
   function automatic logic [2:0] hold_level(input logic ex_hold,
                                             input logic bus_hold);
      logic [2:0] lvl;
      lvl = HOLD_NONE;
      if (ex_hold)
         lvl = HOLD_ID;
      else if (bus_hold)
         lvl = HOLD_PC;
      return lvl;
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: redirect/stall requests in, jump/hold/flush controls out.
// master = pipe_ctrl, slave = ex/arbiter/int source and pc_reg/if_id/id_ex.
interface pipe_ctrl_if;

   logic        ex_jump_flag_i;
   logic [31:0] ex_jump_addr_i;
   logic        ex_hold_i;
   logic        bus_hold_i;
`ifdef PIPE_CTRL_TRAP_EN
   logic        int_req_i;
   logic [31:0] int_addr_i;
   logic        int_ack_o;
`endif
   logic        jump_flag_o;
   logic [31:0] jump_addr_o;
   logic [2:0]  hold_flag_o;
   logic        flush_o;
   logic        stall_timeout_o;

   modport master (
      input  ex_jump_flag_i, ex_jump_addr_i, ex_hold_i, bus_hold_i,
`ifdef PIPE_CTRL_TRAP_EN
      input  int_req_i, int_addr_i,
      output int_ack_o,
`endif
      output jump_flag_o, jump_addr_o, hold_flag_o, flush_o,
      output stall_timeout_o
   );

   modport slave (
      output ex_jump_flag_i, ex_jump_addr_i, ex_hold_i, bus_hold_i,
`ifdef PIPE_CTRL_TRAP_EN
      output int_req_i, int_addr_i,
      input  int_ack_o,
`endif
      input  jump_flag_o, jump_addr_o, hold_flag_o, flush_o,
      input  stall_timeout_o
   );

endinterface

// File: rtl/pipe_ctrl_stall_watchdog.sv
// pipe_ctrl_stall_watchdog: counts consecutive held cycles, sticky timeout.
// Ports: clk, rst_n, i_active (hold level nonzero), o_timeout.
module pipe_ctrl_stall_watchdog
   import pipe_ctrl_pkg::*;
#(
   parameter int STALL_MAX = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_active,
   output logic o_timeout
);

   localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(STALL_MAX);

   logic [WDOG_W-1:0] r_cnt;
   logic              r_flag;
   logic              w_hit;

   // flag shows in the cycle the STALL_MAX-th held cycle occurs
   assign w_hit     = i_active && (r_cnt == LIMIT - 1'b1);
   assign o_timeout = r_flag | w_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_flag <= 1'b0;
      end else begin
         if (!i_active)
            r_cnt <= '0;
         else if (r_cnt != LIMIT)
            r_cnt <= r_cnt + 1'b1;
         if (w_hit)
            r_flag <= 1'b1;
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: redirect/flush/hold sequencing for the 3-stage core.
// Ports: clk, rst_n, bus (pipe_ctrl_if.master); trap path: PIPE_CTRL_TRAP_EN.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int STALL_MAX    = 255
) (
   input  logic         clk,
   input  logic         rst_n,
   pipe_ctrl_if.master  bus
);

   state_e             r_state;
   state_e             w_state_nxt;
   logic [FLUSH_W-1:0] r_flush_cnt;
   logic [FLUSH_W-1:0] w_flush_cnt_nxt;

   logic               w_jump;
   logic [31:0]        w_addr;
   logic               w_flush;
   logic [2:0]         w_hold;
   logic [2:0]         w_hold_out;
   logic               w_timeout;

`ifdef PIPE_CTRL_TRAP_EN
   logic               r_int_pend;
   logic               w_int_pend_nxt;
   logic [31:0]        r_int_addr;
   logic [31:0]        w_int_addr_nxt;
   logic               w_ack;
`endif

   always_comb begin
      w_state_nxt     = r_state;
      w_flush_cnt_nxt = r_flush_cnt;
      w_jump          = JumpDisable;
      w_addr          = '0;
      w_flush         = 1'b0;
      w_hold          = HOLD_NONE;
`ifdef PIPE_CTRL_TRAP_EN
      w_int_pend_nxt  = r_int_pend;
      w_int_addr_nxt  = r_int_addr;
      w_ack           = 1'b0;
`endif
      unique case (r_state)
         ST_IDLE, ST_STALL: begin
            if (bus.ex_jump_flag_i) begin
               w_jump          = JumpEnable;
               w_addr          = bus.ex_jump_addr_i;
               w_flush         = 1'b1;
               w_state_nxt     = ST_FLUSH;
               w_flush_cnt_nxt = FLUSH_W'(FLUSH_CYCLES);
            end else begin
               w_hold      = hold_level(bus.ex_hold_i, bus.bus_hold_i);
               w_state_nxt = bus.ex_hold_i ? ST_STALL : ST_IDLE;
            end
`ifdef PIPE_CTRL_TRAP_EN
            // latch even when ex wins, so the trap survives the flush
            if (bus.int_req_i && !r_int_pend) begin
               w_int_pend_nxt = 1'b1;
               w_int_addr_nxt = bus.int_addr_i;
            end
            if (!bus.ex_jump_flag_i && (bus.int_req_i || r_int_pend))
               w_state_nxt = ST_TRAP_WAIT;
`endif
         end
         ST_FLUSH: begin
            w_flush = 1'b1;
            // wrong-path jumps ignored; bus stall freezes the window
            if (bus.bus_hold_i) begin
               w_hold = HOLD_PC;
            end else begin
               w_flush_cnt_nxt = r_flush_cnt - 1'b1;
               if (w_flush_cnt_nxt == '0)
                  w_state_nxt = ST_IDLE;
            end
         end
`ifdef PIPE_CTRL_TRAP_EN
         ST_TRAP_WAIT: begin
            if (bus.ex_jump_flag_i) begin
               w_jump          = JumpEnable;
               w_addr          = bus.ex_jump_addr_i;
               w_flush         = 1'b1;
               w_state_nxt     = ST_FLUSH;
               w_flush_cnt_nxt = FLUSH_W'(FLUSH_CYCLES);
            end else if (bus.ex_hold_i) begin
               w_hold = HOLD_PC;
            end else begin
               w_jump          = JumpEnable;
               w_addr          = r_int_addr;
               w_flush         = 1'b1;
               w_ack           = 1'b1;
               w_int_pend_nxt  = 1'b0;
               w_state_nxt     = ST_FLUSH;
               w_flush_cnt_nxt = FLUSH_W'(FLUSH_CYCLES);
            end
         end
`endif
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_flush_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_flush_cnt <= w_flush_cnt_nxt;
      end
   end

`ifdef PIPE_CTRL_TRAP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_int_pend <= 1'b0;
         r_int_addr <= '0;
      end else begin
         r_int_pend <= w_int_pend_nxt;
         r_int_addr <= w_int_addr_nxt;
      end
   end

   assign bus.int_ack_o = rst_n & w_ack;
`endif

   // outputs forced quiet while reset is held, whatever the inputs do
   assign w_hold_out      = rst_n ? w_hold : HOLD_NONE;
   assign bus.jump_flag_o = rst_n & w_jump;
   assign bus.jump_addr_o = bus.jump_flag_o ? w_addr : '0;
   assign bus.flush_o     = rst_n & w_flush;
   assign bus.hold_flag_o = w_hold_out;

   pipe_ctrl_stall_watchdog #(
      .STALL_MAX (STALL_MAX)
   ) u_wdog (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_active  (w_hold_out != HOLD_NONE),
      .o_timeout (w_timeout)
   );

   assign bus.stall_timeout_o = w_timeout;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the 3-stage core: collects redirect and stall requests from ex, the bus arbiter and (optionally) the interrupt source, and drives the jump/hold interface consumed by pc_reg, if_id and id_ex. It turns single-cycle requests into registered multi-cycle flush windows, tracks long stalls with a watchdog, and sequences interrupt redirects at safe points.

## Interface
- FLUSH_CYCLES, 1: cycles `flush_o` stays high after the redirect cycle (1..7)
- STALL_MAX, 255: consecutive stall cycles that trip the watchdog (8-bit counter)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ex_jump_flag_i  in  1  ex requests redirect (`JumpEnable`)
- ex_jump_addr_i  in  32  ex redirect target
- ex_hold_i  in  1  ex multi-cycle op busy (div)
- bus_hold_i  in  1  bus arbiter stalls fetch
- int_req_i  in  1  interrupt request, level (macro only)
- int_addr_i  in  32  interrupt vector, sampled with request (macro only)
- int_ack_o  out  1  one-cycle pulse on interrupt redirect (macro only)
- jump_flag_o  out  1  redirect to pc_reg
- jump_addr_o  out  32  redirect target
- hold_flag_o  out  3  hold level: 0 NONE, 1 PC, 2 IF (pc+if_id), 3 ID (pc+if_id+id_ex)
- flush_o  out  1  squash if_id/id_ex contents (insert NOP)
- stall_timeout_o  out  1  sticky watchdog flag

## Operation
- States: IDLE, FLUSH, STALL, TRAP_WAIT (macro only).
- Redirect path combinational (zero latency): when `ex_jump_flag_i`=1 in IDLE or STALL, same cycle `jump_flag_o`=1, `jump_addr_o`=`ex_jump_addr_i`, `flush_o`=1, `hold_flag_o`=0; next state FLUSH, flush counter loaded FLUSH_CYCLES.
- FLUSH: `flush_o`=1, jump_flag_o=0; counter decrements each cycle; at 0 → IDLE. New ex jump in FLUSH is ignored (wrong-path).
- Holds (IDLE/STALL, no jump): `hold_flag_o` = ID if `ex_hold_i`, else PC if `bus_hold_i`, else NONE. `ex_hold_i`=1 → STALL; STALL → IDLE when `ex_hold_i`=0.
- Bus hold during FLUSH: hold_flag_o=PC, flush counter freezes.
- Watchdog: 8-bit counter increments each cycle `hold_flag_o`≠0, clears when 0; reaching STALL_MAX sets `stall_timeout_o`, saturates, cleared only by reset.
- Jump beats hold in the same cycle; hold inputs ignored that cycle.
- `jump_addr_o` is 0 whenever `jump_flag_o`=0.

## Timing
- Reset: state IDLE, counters 0, all outputs 0, pending interrupt cleared.
- Redirect: 0-cycle latency to `jump_flag_o`; pc_reg loads target at next edge.
- Flush window: redirect cycle + FLUSH_CYCLES cycles of `flush_o`=1 (total FLUSH_CYCLES+1 with bus hold absent).
- Hold: combinational, 0-cycle latency; release visible the cycle inputs drop.
- Reset asserted mid-FLUSH/STALL/TRAP_WAIT: immediate return to reset values, no residual flush.

## Configuration
- `PIPE_CTRL_TRAP_EN` defined: int ports present; `int_req_i` in IDLE/STALL latches `int_addr_i` → TRAP_WAIT; TRAP_WAIT holds at PC until `ex_hold_i`=0 and no ex jump, then redirect to latched vector exactly as an ex jump plus one-cycle `int_ack_o`. Ex jump in the same cycle wins; interrupt stays pending, redirect after FLUSH. Requests in FLUSH wait until IDLE.
- Undefined: no int ports, no TRAP_WAIT state; int logic absent.

## Structure
- Hold encodings (HOLD_NONE/PC/IF/ID), `JumpEnable`/`JumpDisable`, state encodings go in defines.v.
- One sub-module natural: `stall_watchdog` (counter + sticky flag).

## Test plan
- Reset then idle → all outputs 0, hold_flag_o=0 every cycle.
- ex_jump_flag_i=1, addr 0x0000_0100, FLUSH_CYCLES=2 → jump_flag_o=1, jump_addr_o=0x100 same cycle; flush_o high 3 cycles; second jump in window ignored.
- ex_hold_i high 5 cycles with bus_hold_i high → hold_flag_o=3 for 5 cycles, then 1 while bus hold remains.
- STALL_MAX=4, ex_hold_i held 6 cycles → stall_timeout_o rises on 4th hold cycle, stays after release until rst_n.
- Macro on: int_req_i with vector 0x0000_0800 during ex_hold_i → TRAP_WAIT hold=1, redirect to 0x800 with int_ack_o pulse the cycle after ex_hold_i drops; same-cycle ex jump delays it past FLUSH.
- rst_n low mid-FLUSH → flush_o, jump_flag_o to 0 immediately; IDLE after release.
